alu_seg_display: RTL
====================

# alu_seg_display

Downstream display stage for the ALU result. It captures the 32-bit `out` word and shows it as eight hex digits on a common-anode, time-multiplexed 7-segment display. A new value is double-buffered and only committed at a frame boundary, so the display never shows a torn value. It sits between the ALU output and the board's `an`/`seg`/`dp` pins.

## Interface
- `SCAN_DIV`, default 100000: clock cycles per digit slot. Minimum 2. Simulation uses 4.
- `clk`  in  1  system clock. All state is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `data_in`  in  32  ALU result word.
- `load`  in  1  when high, capture `data_in` into the pending buffer this cycle.
- `blank_lz`  in  1  when high, blank leading-zero digits. Sampled every cycle.
- `an`  out  8  digit enables, active-low. Bit i is digit i; digit 0 is the least-significant nibble.
- `seg`  out  7  segments, active-low. `seg[0]`=a … `seg[6]`=g.
- `dp`  out  1  decimal point, active-low.

## Operation
- **Prescaler:** `cnt` runs 0..SCAN_DIV-1 and wraps. `tick` = (`cnt`==SCAN_DIV-1).
- **Digit index:** `idx` is 3 bits. It increments on `tick` and wraps 7→0. A frame end is `tick` && `idx`==7.
- **Buffers:**
  - `pending[31:0]`, `pend_flag`, `shown[31:0]`.
  - `load` writes `pending` and sets `pend_flag`. A repeated load overwrites; the last one wins.
  - At frame end, if `pend_flag` is set: `shown`←`pending`, clear `pend_flag`.
  - If `load` coincides with frame end, `shown`←`data_in` directly and `pend_flag` stays clear. The newest value wins.
- **Nibble select:** `nib` = `shown[4*idx+3 : 4*idx]`.
- **Blanking:** with `blank_lz`=1, digit i (i≥1) is blanked when nibbles i..7 of `shown` are all zero. A blanked digit drives its `an` bit high and `seg`=7'h7F. Digit 0 is never blanked.
- **Hex decode** (`seg`, active-low, hex values): 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E.
- **`an`:** exactly one bit is low, bit `idx`, unless that digit is blanked.
- **`dp`:** low only on digit 0 while `pend_flag`=1, signalling that an update is queued. High otherwise.
- **Reset:** `cnt`=0, `idx`=0, `shown`=0, `pending`=0, `pend_flag`=0. Outputs `an`=8'hFF, `seg`=7'h7F, `dp`=1.

## Timing
- `an`, `seg` and `dp` are registered.
- **Output latency:** outputs reflect the `idx`, `shown` and `blank_lz` state from the previous cycle (latency 1).
- **After reset release:**
  - The first edge drives digit 0 of `shown`: `an`=8'hFE, `seg`=7'h40.
  - The first `tick` occurs at the SCAN_DIV-th edge.
- **Digit slot:** each digit is driven for exactly SCAN_DIV cycles. A frame is 8·SCAN_DIV cycles.
- **Load-to-display latency:** a `load` appears on the outputs at most 8·SCAN_DIV+1 cycles later, and never mid-frame.
- **Reset mid-frame:** outputs go to their reset values immediately, without waiting for a clock. Any pending load is discarded.
- **Simultaneous `tick` and `load` outside frame end:** the load goes to `pending` only.

## Structure
- **Shared package `alu_pkg`:**
  - `NUM_DIGITS`=8.
  - The 16-entry `SEG_HEX` constant array.
  - `SEG_BLANK`=7'h7F.
  - `AN_OFF`=8'hFF.
- **Sub-module `hex_to_seg7`:** combinational, 4-bit nibble in → 7-bit active-low `seg` out, using `SEG_HEX`.
- **Top `alu_seg_display`:** prescaler, index counter, buffer logic, blanking and the output registers.

## Test plan
All scenarios use SCAN_DIV=4.
1. **Reset:** assert `rst` asynchronously mid-cycle → `an`=FF, `seg`=7F and `dp`=1 before the next edge. Release → next edge gives `an`=FE, `seg`=40.
2. **Full frame, no blanking:** load 0x1234ABCD with `blank_lz`=0 → after the frame end, digit 0 shows `an`=FE, `seg`=21, and digit 7 shows `an`=7F, `seg`=79. Each digit is held for 4 cycles.
3. **Leading-zero blanking:** `blank_lz`=1, `shown`=0x000000A5 → digit 0 `seg`=12, digit 1 `seg`=08. For digits 2..7, `an`=FF and `seg`=7F. Value 0 → only digit 0 is lit, with `seg`=40.
4. **Mid-frame loads:** load 0x11111111 at `idx`=3, then 0x22222222 at `idx`=5 → digits still show the old value, with `dp`=0 on digit 0. After the frame end all digits show `seg`=24 and `dp` returns to 1.
5. **Load at frame end:** load 0xFFFFFFFF exactly on the frame-end edge → the next digit-0 slot shows `seg`=0E and `dp` stays 1.
6. **Reset discards pending:** load, then reset before the frame end → after release `shown`=0 and `dp`=1.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants for the ALU seven-segment display stage
package alu_pkg;

  // Number of hex digits on the display (one per nibble of the 32-bit word)
  localparam int NUM_DIGITS = 8;

  // Active-low segment patterns, seg[0]=a ... seg[6]=g, indexed by nibble value
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // All segments dark
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // All digit enables inactive
  localparam logic [7:0] AN_OFF = 8'hFF;

endpackage

// File: rtl/alu_seg_display_if.sv
// rtl/alu_seg_display_if.sv - result input and display pin bundle
interface alu_seg_display_if;
  import alu_pkg::*;

  logic [31:0]           data_in;
  logic                  load;
  logic                  blank_lz;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;
  logic                  dp;

  // Source side: supplies the word and controls, observes the pins
  modport master (
    output data_in,
    output load,
    output blank_lz,
    input  an,
    input  seg,
    input  dp
  );

  // Display side: consumes the word and controls, drives the pins
  modport slave (
    input  data_in,
    input  load,
    input  blank_lz,
    output an,
    output seg,
    output dp
  );

endinterface

// File: rtl/alu_seg_display_hex_to_seg7.sv
// rtl/alu_seg_display_hex_to_seg7.sv - nibble to active-low seven-segment decoder
module hex_to_seg7
  import alu_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  // Pure table lookup; every nibble value has a defined glyph
  always_comb begin
    o_seg = SEG_HEX[i_nib];
  end

endmodule

// File: rtl/alu_seg_display.sv
// rtl/alu_seg_display.sv - double-buffered eight-digit multiplexed hex display
module alu_seg_display
  import alu_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst,
  alu_seg_display_if.slave    bus
);

  localparam int              CW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [2:0]      IDX_MAX = 3'(NUM_DIGITS - 1);

  logic [CW-1:0]         r_cnt;
  logic [2:0]            r_idx;
  logic [31:0]           r_pending;
  logic                  r_pend_flag;
  logic [31:0]           r_shown;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;
  logic                  r_dp;

  logic                  w_tick;
  logic                  w_frame_end;
  logic [31:0]           w_upper;
  logic [3:0]            w_nib;
  logic                  w_blank;
  logic [6:0]            w_hex_seg;
  logic [NUM_DIGITS-1:0] w_an_sel;

  // Slot and frame boundary strobes
  always_comb begin
    w_tick      = (r_cnt == CNT_MAX);
    w_frame_end = w_tick && (r_idx == IDX_MAX);
  end

  // Prescaler: one digit slot every SCAN_DIV cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Digit index advances once per slot and wraps naturally at 7
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (w_tick) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  // Double buffer: loads queue in pending; shown changes only at frame end,
  // and a load landing exactly on frame end bypasses the queue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending   <= '0;
      r_pend_flag <= 1'b0;
      r_shown     <= '0;
    end else begin
      if (bus.load) begin
        r_pending <= bus.data_in;
      end
      if (w_frame_end) begin
        r_pend_flag <= 1'b0;
        if (bus.load) begin
          r_shown <= bus.data_in;
        end else if (r_pend_flag) begin
          r_shown <= r_pending;
        end
      end else if (bus.load) begin
        r_pend_flag <= 1'b1;
      end
    end
  end

  // Current digit nibble and leading-zero test: the digit is blanked when it
  // and every more-significant nibble are zero (digit 0 always lit)
  always_comb begin
    w_upper  = r_shown >> {r_idx, 2'b00};
    w_nib    = w_upper[3:0];
    w_blank  = bus.blank_lz && (r_idx != 3'd0) && (w_upper == 32'd0);
    w_an_sel = ~(NUM_DIGITS'(1) << r_idx);
  end

  hex_to_seg7 u_hex (
    .i_nib (w_nib),
    .o_seg (w_hex_seg)
  );

  // Registered pins; reset forces everything dark immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_blank ? AN_OFF : w_an_sel;
      r_seg <= w_blank ? SEG_BLANK : w_hex_seg;
      r_dp  <= !((r_idx == 3'd0) && r_pend_flag);
    end
  end

  // Drive the pin bundle from the output registers
  always_comb begin
    bus.an  = r_an;
    bus.seg = r_seg;
    bus.dp  = r_dp;
  end

endmodule
